// File: rtl/sprite_renderer_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, sync
// polarity encoding and the 24-bit colour type.
package sprite_renderer_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  localparam int COLOR_W = 24;
  typedef logic [COLOR_W-1:0] rgb_t;

  function automatic logic sync_level(
    input logic on,
    input logic pol
  );
    return on ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sprite_renderer_timing.sv
// Raster timing generator: h/v counters, active flag,
// raw sync levels and the start-of-vblank latch strobe.
module vga_timing
  import sprite_renderer_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = SYNC_ACT_LOW,
  parameter int   HCW      = $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP+1),
  parameter int   VCW      = $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [HCW-1:0] h_cnt,
  output logic [VCW-1:0] v_cnt,
  output logic           active,
  output logic           hs_raw,
  output logic           vs_raw,
  output logic           latch
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_ON  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_OFF = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_ON  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_OFF = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;

  // Advance the raster position; v steps when h wraps
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Counter registers restart at the top-left on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;
  assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_raw = sync_level(
    (h_cnt_q >= HS_ON) && (h_cnt_q < HS_OFF), SYNC_POL);
  assign vs_raw = sync_level(
    (v_cnt_q >= VS_ON) && (v_cnt_q < VS_OFF), SYNC_POL);
  assign latch  = (h_cnt_q == '0) && (v_cnt_q == V_VIS);

endmodule

// File: rtl/sprite_renderer.sv
// Rectangle sprite renderer: shadowed geometry, two-stage
// hit/priority pipeline, aligned colour and sync outputs.
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic SYNC_POL  = SYNC_ACT_LOW,
  parameter int   NUM_RECTS = 4,
  parameter int   XW        = 10,
  parameter int   YW        = 9
) (
  input  logic                        clk_vga,
  input  logic                        rst_n,
  input  logic [NUM_RECTS*XW-1:0]     rect_x0,
  input  logic [NUM_RECTS*YW-1:0]     rect_y0,
  input  logic [NUM_RECTS*XW-1:0]     rect_w,
  input  logic [NUM_RECTS*YW-1:0]     rect_h,
  input  logic [NUM_RECTS*COLOR_W-1:0] rect_color,
  input  logic [NUM_RECTS-1:0]        rect_en,
  input  logic [COLOR_W-1:0]          bg_color,
  output logic                        frame_start,
  output logic                        VGA_BLANK_N,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B
);

  localparam int HCW = $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP+1);
  localparam int VCW = $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP+1);
  // Compare width wide enough for both counter and x0+w
  localparam int HXW = (HCW > XW + 1) ? HCW : XW + 1;
  localparam int VYW = (VCW > YW + 1) ? VCW : YW + 1;

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           active;
  logic           hs_raw;
  logic           vs_raw;
  logic           latch;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .HCW      (HCW),
    .VCW      (VCW)
  ) u_timing (
    .clk    (clk_vga),
    .rst_n  (rst_n),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .latch  (latch)
  );

  logic [NUM_RECTS*XW-1:0]      sh_x0_q, sh_x0_d;
  logic [NUM_RECTS*YW-1:0]      sh_y0_q, sh_y0_d;
  logic [NUM_RECTS*XW-1:0]      sh_w_q, sh_w_d;
  logic [NUM_RECTS*YW-1:0]      sh_h_q, sh_h_d;
  logic [NUM_RECTS*COLOR_W-1:0] sh_col_q, sh_col_d;
  logic [NUM_RECTS-1:0]         sh_en_q, sh_en_d;
  logic                         fs_q, fs_d;

  logic [NUM_RECTS-1:0] hit_q, hit_d;
  logic                 act1_q, act1_d;
  logic                 hs1_q, hs1_d;
  logic                 vs1_q, vs1_d;

  rgb_t rgb_q, rgb_d;
  rgb_t pix;
  logic blank_n_q, blank_n_d;
  logic hs2_q, hs2_d;
  logic vs2_q, vs2_d;

  // Capture geometry only at the first clock of vertical blanking
  always_comb begin
    sh_x0_d  = sh_x0_q;
    sh_y0_d  = sh_y0_q;
    sh_w_d   = sh_w_q;
    sh_h_d   = sh_h_q;
    sh_col_d = sh_col_q;
    sh_en_d  = sh_en_q;
    fs_d     = latch;
    if (latch) begin
      sh_x0_d  = rect_x0;
      sh_y0_d  = rect_y0;
      sh_w_d   = rect_w;
      sh_h_d   = rect_h;
      sh_col_d = rect_color;
      sh_en_d  = rect_en;
    end
  end

  // Stage 1: per-rectangle hit test against shadow geometry
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = sh_en_q[i]
        & (HXW'(h_cnt) >= HXW'(sh_x0_q[i*XW +: XW]))
        & (HXW'(h_cnt) < HXW'(sh_x0_q[i*XW +: XW])
                         + HXW'(sh_w_q[i*XW +: XW]))
        & (VYW'(v_cnt) >= VYW'(sh_y0_q[i*YW +: YW]))
        & (VYW'(v_cnt) < VYW'(sh_y0_q[i*YW +: YW])
                         + VYW'(sh_h_q[i*YW +: YW]));
    end
    act1_d = active;
    hs1_d  = hs_raw;
    vs1_d  = vs_raw;
  end

  // Stage 2: lowest-index hit wins, blank forces black
  always_comb begin
    pix = bg_color;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_q[i]) pix = sh_col_q[i*COLOR_W +: COLOR_W];
    end
    rgb_d     = act1_q ? pix : '0;
    blank_n_d = act1_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
  end

  // Shadow, frame strobe and pipeline registers
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      sh_x0_q   <= '0;
      sh_y0_q   <= '0;
      sh_w_q    <= '0;
      sh_h_q    <= '0;
      sh_col_q  <= '0;
      sh_en_q   <= '0;
      fs_q      <= 1'b0;
      hit_q     <= '0;
      act1_q    <= 1'b0;
      hs1_q     <= ~SYNC_POL;
      vs1_q     <= ~SYNC_POL;
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hs2_q     <= ~SYNC_POL;
      vs2_q     <= ~SYNC_POL;
    end else begin
      sh_x0_q   <= sh_x0_d;
      sh_y0_q   <= sh_y0_d;
      sh_w_q    <= sh_w_d;
      sh_h_q    <= sh_h_d;
      sh_col_q  <= sh_col_d;
      sh_en_q   <= sh_en_d;
      fs_q      <= fs_d;
      hit_q     <= hit_d;
      act1_q    <= act1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      rgb_q     <= rgb_d;
      blank_n_q <= blank_n_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
    end
  end

  assign frame_start = fs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer on a reduced
// 16x12 raster (24 clocks/line, 18 lines/frame).
module tb_sprite_renderer;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int N  = 2;
  localparam int XW = 10;
  localparam int YW = 9;

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] BG    = 24'h202020;
  localparam logic [27:0] RST_V = {4'b0110, 24'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*XW-1:0] rect_x0 = '0;
  logic [N*YW-1:0] rect_y0 = '0;
  logic [N*XW-1:0] rect_w = '0;
  logic [N*YW-1:0] rect_h = '0;
  logic [N*24-1:0] rect_color = '0;
  logic [N-1:0]    rect_en = '0;
  logic [23:0]     bg_color = '0;
  logic frame_start, VGA_BLANK_N, VGA_HS, VGA_VS;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  sprite_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .NUM_RECTS(N), .XW(XW), .YW(YW)
  ) dut (
    .clk_vga(clk), .rst_n(rst_n),
    .rect_x0(rect_x0), .rect_y0(rect_y0),
    .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color), .rect_en(rect_en),
    .bg_color(bg_color), .frame_start(frame_start),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [27:0] exp;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int cyc;
  int n_pass = 0;
  int n_tot = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [27:0] obs();
    return {VGA_BLANK_N, VGA_HS, VGA_VS, frame_start,
            VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic chk(input string nm, input logic [27:0] got,
                     input logic [27:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got blank/hs/vs/fs=%b rgb=%h, required blank/hs/vs/fs=%b rgb=%h",
                  nm, got[27:24], got[23:0], want[27:24], want[23:0]);
  endtask

  // Monitor: compare whenever the DUT reaches the head entry's cycle
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      if (cyc == sb[0].cyc) begin
        chk(nm_q[0], obs(), sb[0].exp);
        void'(sb.pop_front());
        void'(nm_q.pop_front());
      end else if (cyc > sb[0].cyc) begin
        n_tot++;
        $display("FAIL %s: sample cycle %0d missed at %0d, required on time",
                 nm_q[0], sb[0].cyc, cyc);
        void'(sb.pop_front());
        void'(nm_q.pop_front());
      end
    end
  end

  task automatic push_raw(input string nm, input int c,
                          input logic [27:0] e);
    exp_t x;
    x.cyc = c;
    x.exp = e;
    sb.push_back(x);
    nm_q.push_back(nm);
  endtask

  // Expected outputs for counter position (h,v) in frame f
  task automatic exp_at(input string nm, input int f, input int h,
                        input int v, input logic [23:0] rgb);
    int c;
    logic act;
    act = (h < HA) && (v < VA);
    c = f * FR + v * HT + h + 2;
    push_raw(nm, c, {act,
      !(h >= HA + HF && h < HA + HF + HS),
      !(v >= VA + VF && v < VA + VF + VS),
      (c % FR) == (VA * HT + 1),
      act ? rgb : 24'h0});
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_tot++;
      $display("FAIL drain: %0d entries left after %0d cycles, required 0",
               sb.size(), limit);
      sb.delete();
      nm_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_rect(input int i, input int x0, input int y0,
                          input int w, input int h,
                          input logic [23:0] c);
    rect_x0[i*XW +: XW]    = XW'(x0);
    rect_y0[i*YW +: YW]    = YW'(y0);
    rect_w[i*XW +: XW]     = XW'(w);
    rect_h[i*YW +: YW]     = YW'(h);
    rect_color[i*24 +: 24] = c;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_state", obs(), RST_V);

    // Sync timing, first frame background, second frame drawn
    bg_color = BG;
    set_rect(0, 0, 0, HA, VA, RED);
    rect_en = 2'b01;
    @(negedge clk);
    #1 rst_n = 1'b1;
    push_raw("blank_cyc1", 1, RST_V);
    exp_at("f0_first_px", 0, 0, 0, BG);
    exp_at("f0_mid_bg", 0, 8, 6, BG);
    exp_at("last_vis_col", 0, 15, 6, BG);
    exp_at("h_front_porch", 0, 16, 6, BG);
    exp_at("hs_start", 0, 18, 6, BG);
    exp_at("hs_last", 0, 20, 6, BG);
    exp_at("hs_end", 0, 21, 6, BG);
    exp_at("frame_start_on", 0, 23, 11, BG);
    exp_at("frame_start_off", 0, 0, 12, BG);
    exp_at("v_front_porch", 0, 0, 13, BG);
    exp_at("vs_start", 0, 0, 14, BG);
    exp_at("vs_last", 0, 23, 15, BG);
    exp_at("vs_end", 0, 0, 16, BG);
    exp_at("f1_first_px", 1, 0, 0, RED);
    exp_at("f1_last_px", 1, 15, 11, RED);
    drain(3 * FR);

    // Priority: rect0 over rect1
    set_rect(0, 2, 2, 4, 4, RED);
    set_rect(1, 4, 4, 4, 4, BLUE);
    rect_en = 2'b11;
    do_reset();
    exp_at("prio_f0_bg", 0, 4, 4, BG);
    exp_at("prio_left_bg", 1, 1, 2, BG);
    exp_at("prio_r0", 1, 4, 4, RED);
    exp_at("prio_overlap", 1, 5, 5, RED);
    exp_at("prio_r1a", 1, 6, 6, BLUE);
    exp_at("prio_r1b", 1, 7, 7, BLUE);
    exp_at("prio_out_bg", 1, 8, 8, BG);
    drain(3 * FR);

    // Shadow latch: move rect0 mid-frame
    set_rect(0, 2, 2, 4, 8, RED);
    set_rect(1, 0, 0, 0, 0, 24'h0);
    rect_en = 2'b01;
    do_reset();
    exp_at("shd_old_pos", 1, 2, 7, RED);
    exp_at("shd_new_not_yet", 1, 9, 7, BG);
    exp_at("shd_frame_start", 1, 23, 11, BG);
    exp_at("shd_old_gone", 2, 2, 7, BG);
    exp_at("shd_new_pos", 2, 9, 7, RED);
    wait_cyc(FR + 4 * HT);
    set_rect(0, 9, 2, 4, 8, RED);
    drain(4 * FR);

    // Clipping and zero width
    bg_color = 24'h0A0B0C;
    set_rect(0, 14, 10, 10, 10, RED);
    set_rect(1, 0, 0, 0, 5, GREEN);
    rect_en = 2'b11;
    do_reset();
    exp_at("w0_origin", 1, 0, 0, 24'h0A0B0C);
    exp_at("clip_above", 1, 14, 9, 24'h0A0B0C);
    exp_at("clip_left", 1, 13, 10, 24'h0A0B0C);
    exp_at("clip_tl", 1, 14, 10, RED);
    exp_at("clip_tr", 1, 15, 10, RED);
    exp_at("clip_porch", 1, 16, 10, RED);
    exp_at("clip_col0", 1, 0, 11, 24'h0A0B0C);
    exp_at("clip_br", 1, 15, 11, RED);
    exp_at("clip_line0", 2, 0, 0, 24'h0A0B0C);
    drain(4 * FR);

    // Disabled full-screen rect, porches black
    bg_color = 24'h123456;
    set_rect(0, 0, 0, HA, VA, RED);
    set_rect(1, 0, 0, 0, 0, 24'h0);
    rect_en = 2'b00;
    do_reset();
    exp_at("dis_first", 1, 0, 0, 24'h123456);
    exp_at("dis_porch", 1, 16, 3, 24'h123456);
    exp_at("dis_mid", 1, 8, 6, 24'h123456);
    exp_at("dis_last", 1, 15, 11, 24'h123456);
    exp_at("dis_vporch", 1, 5, 13, 24'h123456);
    drain(3 * FR);

    // Reset mid-frame
    bg_color = BG;
    rect_en = 2'b01;
    do_reset();
    exp_at("mrst_pre", 1, 5, 2, RED);
    drain(3 * FR);
    wait_cyc(FR + 5 * HT + 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), RST_V);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    push_raw("mrst_cyc1", 1, RST_V);
    exp_at("mrst_first_px", 0, 0, 0, BG);
    exp_at("mrst_f0_bg", 0, 5, 2, BG);
    exp_at("mrst_f1_red", 1, 5, 2, RED);
    drain(3 * FR);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
